exp_pipe: RTL and testbench
===========================

EXP_PIPE -- requirements
Module: exp_pipe

Interface
REQ-001 SHALL declare parameter INT_W, default 6, signed integer bits of input x.
REQ-002 SHALL declare parameter FRAC_W, default 8, fraction bits of input x.
REQ-003 SHALL declare parameter OUT_W, default 32, unsigned result width.
REQ-004 SHALL declare parameter OUT_FRAC, default 18, result fraction bits.
REQ-005 SHALL declare parameter INT_MIN, default -5, lowest integer part with a table entry.
REQ-006 SHALL declare parameter INT_MAX, default 9, highest integer part with a table entry.
REQ-007 SHALL have one clock and a synchronous active-high reset: clk  in  1  clock, rising edge; rst  in  1  synchronous reset, active high.
REQ-008 SHALL have port in_valid  in  1  input sample valid.
REQ-009 SHALL have port in_ready  out  1  block accepts sample this cycle.
REQ-010 SHALL have port in_x  in  INT_W+FRAC_W  two's-complement fixed-point x.
REQ-011 SHALL have port out_valid  out  1  result valid.
REQ-012 SHALL have port out_ready  in  1  downstream accepts result.
REQ-013 SHALL have port out_exp  out  OUT_W  e^x, unsigned, OUT_FRAC fraction bits.
REQ-014 SHALL have port out_ovf  out  1  result saturated high.
REQ-015 SHALL have port out_udf  out  1  result flushed to zero.

Function
REQ-016 SHALL split x into i = floor(x) (upper INT_W bits) and f = lower FRAC_W bits, 0 <= f < 1.
REQ-017 SHALL hold table T[k] = round(e^k * 2^OUT_FRAC) for k = INT_MIN..INT_MAX, computed at elaboration; defaults give T[0]=262144, T[1]=712581, T[9]=2124174833.
REQ-018 SHALL compute poly p(f) with OUT_FRAC fraction bits and OUT_FRAC+2 total bits; form per REQ-035/036; alignment of f terms to OUT_FRAC truncates.
REQ-019 SHALL compute result = (T[i] * p + 2^(OUT_FRAC-1)) >> OUT_FRAC, full-width product, round half up.
REQ-020 SHALL, if i > INT_MAX or rounded result >= 2^OUT_W, output all ones with out_ovf=1.
REQ-021 SHALL, if i < INT_MIN, output 0 with out_udf=1; out_ovf and out_udf never both 1.
REQ-022 SHALL be a 3-stage pipeline: S1 range check, table lookup, poly; S2 multiply; S3 round/saturate into output register.
REQ-023 SHALL have latency 3 cycles from accepted input to out_valid with no backpressure.
REQ-024 SHALL advance all stages together when adv = out_ready | ~out_valid; in_ready = adv (combinational).
REQ-025 SHALL accept a sample when in_valid & in_ready; a bubble SHALL propagate as cleared stage valid.
REQ-026 SHALL hold out_exp, out_ovf, out_udf and all stage contents stable while out_valid & ~out_ready.
REQ-027 SHALL sustain throughput of 1 result per cycle with out_ready held high.
REQ-028 SHALL preserve result order; no sample dropped or duplicated.
REQ-029 SHALL, on in_valid high with a full stalled pipe, hold in_ready low and not capture in_x.

Reset
REQ-030 SHALL clear all stage valids and out_valid on rst; in-flight samples discarded.
REQ-031 SHALL reset out_exp, out_ovf, out_udf to 0.
REQ-032 SHALL hold in_ready low while rst is high and for no cycles after it.
REQ-033 SHALL give rst priority over simultaneous in_valid/out_ready.

Configuration
REQ-034 SHALL use macro EXP_PIPE_TAYLOR2_EN to select poly order.
REQ-035 SHALL, with EXP_PIPE_TAYLOR2_EN defined, use p = 1 + f + f*f/2.
REQ-036 SHALL, without EXP_PIPE_TAYLOR2_EN, use p = 1 + f and omit the squarer; latency unchanged.

Verification
REQ-037 SHALL test x=0.0 -> out_exp=262144, flags 0, out_valid 3 cycles after accept.
REQ-038 SHALL test x=0.5 -> 425984 with EXP_PIPE_TAYLOR2_EN, 393216 without; x=1.5 with macro -> 1157944.
REQ-039 SHALL test x=10.0 -> 0xFFFFFFFF, out_ovf=1; x=9+255/256 with macro -> 0xFFFFFFFF, out_ovf=1.
REQ-040 SHALL test x=-6.0 -> 0, out_udf=1; x=-5.0 -> 1766, flags 0.
REQ-041 SHALL test 8 back-to-back inputs with out_ready low cycles 4-6 -> in_ready low during stall, outputs held, all 8 results in order.
REQ-042 SHALL test rst asserted with 2 samples in flight -> out_valid 0 next cycle; no stale result appears afterwards.

Source files
------------

// File: rtl/exp_pipe.sv
// e^x for a signed fixed-point x: table e^i times a polynomial in frac(x), three pipeline stages.
// Optional macro EXP_PIPE_TAYLOR2_EN adds the f*f/2 term; otherwise p = 1 + f.
module exp_pipe #(
   parameter int INT_W    = 6,
   parameter int FRAC_W   = 8,
   parameter int OUT_W    = 32,
   parameter int OUT_FRAC = 18,
   parameter int INT_MIN  = -5,
   parameter int INT_MAX  = 9
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic [INT_W+FRAC_W-1:0] in_x,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic [OUT_W-1:0]        out_exp,
   output logic                    out_ovf,
   output logic                    out_udf
);

   localparam int X_W    = INT_W + FRAC_W;
   localparam int N_TAB  = INT_MAX - INT_MIN + 1;
   localparam int P_W    = OUT_FRAC + 2;
   localparam int PROD_W = OUT_W + P_W;
   localparam int F_SH   = OUT_FRAC - FRAC_W;
   localparam real E_CONST = 2.718281828459045;

   function automatic logic [N_TAB*OUT_W-1:0] build_tab();
      logic [N_TAB*OUT_W-1:0] tab;
      real                    e_k;
      tab = '0;
      for (int k = INT_MIN; k <= INT_MAX; k++) begin
         e_k = 1.0;
         if (k >= 0) begin
            for (int j = 0; j < k; j++) e_k = e_k * E_CONST;
         end else begin
            for (int j = 0; j < -k; j++) e_k = e_k / E_CONST;
         end
         // real-to-integer cast rounds to nearest
         tab[(k-INT_MIN)*OUT_W +: OUT_W] = OUT_W'(longint'(e_k * (2.0 ** OUT_FRAC)));
      end
      return tab;
   endfunction

   localparam logic [N_TAB*OUT_W-1:0] TAB      = build_tab();
   localparam logic [P_W-1:0]         P_ONE    = P_W'(1) << OUT_FRAC;
   localparam logic [PROD_W:0]        RND_HALF = (PROD_W+1)'(1) << (OUT_FRAC - 1);

   // Stage registers
   logic                v1_q, ovf1_q, udf1_q;
   logic [OUT_W-1:0]    t1_q;
   logic [P_W-1:0]      p1_q;
   logic                v2_q, ovf2_q, udf2_q;
   logic [PROD_W-1:0]   prod2_q;
   logic                out_valid_q, out_ovf_q, out_udf_q;
   logic [OUT_W-1:0]    out_exp_q;

   logic                adv;
   assign adv      = out_ready | ~out_valid_q;
   assign in_ready = adv & ~rst;

   // S1: range check, table lookup, polynomial
   logic signed [INT_W-1:0] i_s1;
   logic [FRAC_W-1:0]       f_s1;
   logic                    ovf_s1, udf_s1;
   logic [OUT_W-1:0]        t_s1;
   logic [P_W-1:0]          f_al, p_s1;

   assign i_s1 = in_x[X_W-1:FRAC_W];
   assign f_s1 = in_x[FRAC_W-1:0];

   always_comb begin
      ovf_s1 = int'(i_s1) > INT_MAX;
      udf_s1 = int'(i_s1) < INT_MIN;
      t_s1   = '0;
      if (!ovf_s1 && !udf_s1) t_s1 = TAB[(int'(i_s1) - INT_MIN) * OUT_W +: OUT_W];
   end

   if (F_SH >= 0) begin : g_f_up
      assign f_al = P_W'(f_s1) << F_SH;
   end else begin : g_f_dn
      assign f_al = P_W'(f_s1 >> (-F_SH));
   end

`ifdef EXP_PIPE_TAYLOR2_EN
   localparam int SQ_SH = OUT_FRAC - (2 * FRAC_W + 1);
   logic [2*FRAC_W-1:0] sq_s1;
   logic [P_W-1:0]      sq_al;
   assign sq_s1 = {FRAC_W'(0), f_s1} * {FRAC_W'(0), f_s1};
   // f*f carries 2*FRAC_W fraction bits; the /2 is folded into the alignment shift
   if (SQ_SH >= 0) begin : g_sq_up
      assign sq_al = P_W'(sq_s1) << SQ_SH;
   end else begin : g_sq_dn
      assign sq_al = P_W'(sq_s1 >> (-SQ_SH));
   end
   assign p_s1 = P_ONE + f_al + sq_al;
`else
   assign p_s1 = P_ONE + f_al;
`endif

   // S2: full-width multiply
   logic [PROD_W-1:0] prod_d;
   assign prod_d = {{P_W{1'b0}}, t1_q} * {{OUT_W{1'b0}}, p1_q};

   // S3: round half up, then saturate
   logic [PROD_W:0]   rnd, shifted;
   logic [OUT_W-1:0]  exp_d;
   logic              ovf_d, udf_d, big;

   assign rnd     = {1'b0, prod2_q} + RND_HALF;
   assign shifted = rnd >> OUT_FRAC;
   assign big     = |shifted[PROD_W:OUT_W];

   always_comb begin
      exp_d = shifted[OUT_W-1:0];
      ovf_d = 1'b0;
      udf_d = 1'b0;
      if (ovf2_q || big) begin
         exp_d = '1;
         ovf_d = 1'b1;
      end else if (udf2_q) begin
         exp_d = '0;
         udf_d = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         v1_q        <= 1'b0;
         ovf1_q      <= 1'b0;
         udf1_q      <= 1'b0;
         t1_q        <= '0;
         p1_q        <= '0;
         v2_q        <= 1'b0;
         ovf2_q      <= 1'b0;
         udf2_q      <= 1'b0;
         prod2_q     <= '0;
         out_valid_q <= 1'b0;
         out_exp_q   <= '0;
         out_ovf_q   <= 1'b0;
         out_udf_q   <= 1'b0;
      end else if (adv) begin
         v1_q        <= in_valid;
         v2_q        <= v1_q;
         out_valid_q <= v2_q;
         // data only moves with a valid sample so bubbles leave registers untouched
         if (in_valid) begin
            ovf1_q <= ovf_s1;
            udf1_q <= udf_s1;
            t1_q   <= t_s1;
            p1_q   <= p_s1;
         end
         if (v1_q) begin
            ovf2_q  <= ovf1_q;
            udf2_q  <= udf1_q;
            prod2_q <= prod_d;
         end
         if (v2_q) begin
            out_exp_q <= exp_d;
            out_ovf_q <= ovf_d;
            out_udf_q <= udf_d;
         end
      end
   end

   assign out_valid = out_valid_q;
   assign out_exp   = out_exp_q;
   assign out_ovf   = out_ovf_q;
   assign out_udf   = out_udf_q;

endmodule

// File: tb/tb_exp_pipe.sv
// Bench for exp_pipe: directed corner values, stall, reset flush and random traffic
// scored against an arithmetic reference of e^x.
module tb_exp_pipe;

   localparam int INT_W    = 6;
   localparam int FRAC_W   = 8;
   localparam int OUT_W    = 32;
   localparam int OUT_FRAC = 18;
   localparam int INT_MIN  = -5;
   localparam int INT_MAX  = 9;
   localparam int X_W      = INT_W + FRAC_W;
   localparam int R_W      = OUT_W + 2;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             in_valid = 1'b0;
   logic             in_ready;
   logic [X_W-1:0]   in_x = '0;
   logic             out_valid;
   logic             out_ready = 1'b1;
   logic [OUT_W-1:0] out_exp;
   logic             out_ovf, out_udf;

   int               n_checks = 0;
   int               n_errors = 0;
   int               stale_cnt = 0;
   bit               count_stale = 1'b0;
   logic [R_W-1:0]   exp_q[$];
   logic [R_W-1:0]   mon_e;

   exp_pipe #(
      .INT_W(INT_W), .FRAC_W(FRAC_W), .OUT_W(OUT_W), .OUT_FRAC(OUT_FRAC),
      .INT_MIN(INT_MIN), .INT_MAX(INT_MAX)
   ) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready), .in_x(in_x),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_exp(out_exp), .out_ovf(out_ovf), .out_udf(out_udf)
   );

   // clock
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   // reference: e^i * (1 + f [+ f^2/2]) with saturation, from the arithmetic rules directly
   function automatic logic [R_W-1:0] model(input logic [X_W-1:0] x);
      int     ip;
      longint f, t, p, r;
      ip = int'($signed(x[X_W-1:FRAC_W]));
      f  = longint'(x[FRAC_W-1:0]);
      if (ip > INT_MAX) return {{OUT_W{1'b1}}, 2'b10};
      if (ip < INT_MIN) return {{OUT_W{1'b0}}, 2'b01};
      t = longint'($floor($exp(real'(ip)) * (2.0 ** OUT_FRAC) + 0.5));
      p = (longint'(1) << OUT_FRAC) + ((f << OUT_FRAC) >> FRAC_W);
`ifdef EXP_PIPE_TAYLOR2_EN
      p = p + (((f * f) << OUT_FRAC) >> (2 * FRAC_W + 1));
`endif
      r = (t * p + (longint'(1) << (OUT_FRAC - 1))) >> OUT_FRAC;
      if (r >= (longint'(1) << OUT_W)) return {{OUT_W{1'b1}}, 2'b10};
      return {r[OUT_W-1:0], 2'b00};
   endfunction

   function automatic logic [X_W-1:0] rand_x();
      int ip, fr;
      logic [X_W-1:0] x;
      if ($urandom_range(0, 7) == 0) begin
         x = X_W'($urandom_range(0, (1 << X_W) - 1));
      end else begin
         ip = $urandom_range(0, 17) - 7;
         fr = $urandom_range(0, 255);
         x  = {ip[INT_W-1:0], fr[FRAC_W-1:0]};
      end
      return x;
   endfunction

   // scoreboard: push model on accept, pop and compare on output handshake
   always @(negedge clk) begin
      if (rst) begin
         exp_q.delete();
      end else begin
         if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
               check("unexpected_out", 64'(1), 64'(0));
            end else begin
               mon_e = exp_q.pop_front();
               check("sb_exp", 64'(out_exp), 64'(mon_e[R_W-1:2]));
               check("sb_flags", 64'({out_ovf, out_udf}), 64'(mon_e[1:0]));
            end
         end
         if (in_valid && in_ready) exp_q.push_back(model(in_x));
         if (count_stale && out_valid) stale_cnt++;
      end
   end

   task automatic run_directed(input string tag, input logic [X_W-1:0] x,
                               input logic [OUT_W-1:0] e_val, input logic o, input logic u);
      int lat;
      bit seen;
      @(posedge clk); #1;
      out_ready = 1'b1;
      in_valid  = 1'b1;
      in_x      = x;
      @(posedge clk); #1;
      in_valid = 1'b0;
      lat  = 0;
      seen = 1'b0;
      for (int k = 1; k <= 10 && !seen; k++) begin
         @(negedge clk);
         if (out_valid) begin
            seen = 1'b1;
            lat  = k;
         end
      end
      check({tag, "_lat"}, 64'(lat), 64'(3));
      if (seen) begin
         check({tag, "_exp"}, 64'(out_exp), 64'(e_val));
         check({tag, "_flags"}, 64'({out_ovf, out_udf}), 64'({o, u}));
      end
   endtask

   task automatic stall_test();
      logic [X_W-1:0] xs[8];
      int sent;
      sent = 0;
      for (int i = 0; i < 8; i++) xs[i] = rand_x();
      for (int c = 1; c <= 20; c++) begin
         @(posedge clk); #1;
         out_ready = !(c >= 4 && c <= 6);
         in_valid  = (sent < 8);
         if (sent < 8) in_x = xs[sent];
         #1;
         if (c >= 4 && c <= 6) begin
            check("stall_in_ready", 64'(in_ready), 64'(0));
            check("stall_out_valid", 64'(out_valid), 64'(1));
            if (exp_q.size() > 0) check("stall_hold", 64'(out_exp), 64'(exp_q[0][R_W-1:2]));
         end
         if (in_valid && in_ready) sent++;
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      check("stall_sent", 64'(sent), 64'(8));
   endtask

   task automatic random_test(input int n);
      bit acc;
      acc = 1'b0;
      for (int c = 0; c < n; c++) begin
         @(posedge clk); #1;
         out_ready = ($urandom_range(0, 3) != 0);
         if (!in_valid || acc) begin
            in_valid = ($urandom_range(0, 3) != 0);
            in_x     = rand_x();
         end
         #1;
         acc = in_valid && in_ready;
      end
      @(posedge clk); #1;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      repeat (6) @(posedge clk);
      #1;
      check("rand_drained", 64'(exp_q.size()), 64'(0));
   endtask

   task automatic reset_flush_test();
      @(posedge clk); #1;
      out_ready = 1'b0;
      in_valid  = 1'b1;
      in_x      = rand_x();
      @(posedge clk); #1;
      in_x = rand_x();
      @(posedge clk); #1;
      in_valid = 1'b0;
      @(posedge clk); #1;
      check("pre_rst_valid", 64'(out_valid), 64'(1));
      rst       = 1'b1;
      in_valid  = 1'b1;
      out_ready = 1'b1;
      #1;
      check("rst_in_ready", 64'(in_ready), 64'(0));
      @(posedge clk); #1;
      check("rst_out_valid", 64'(out_valid), 64'(0));
      check("rst_out_exp", 64'(out_exp), 64'(0));
      rst         = 1'b0;
      in_valid    = 1'b0;
      count_stale = 1'b1;
      repeat (10) @(posedge clk);
      #1;
      count_stale = 1'b0;
      check("no_stale", 64'(stale_cnt), 64'(0));
   endtask

   initial begin
      // reset
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check("reset_out_valid", 64'(out_valid), 64'(0));
      check("reset_out_exp", 64'(out_exp), 64'(0));
      check("reset_flags", 64'({out_ovf, out_udf}), 64'(0));
      check("reset_in_ready", 64'(in_ready), 64'(0));
      rst = 1'b0;
      #1;
      check("ready_after_rst", 64'(in_ready), 64'(1));

      run_directed("x_0", 14'h0000, 32'd262144, 1'b0, 1'b0);
`ifdef EXP_PIPE_TAYLOR2_EN
      run_directed("x_0p5", 14'h0080, 32'd425984, 1'b0, 1'b0);
      run_directed("x_1p5", 14'h0180, 32'd1157944, 1'b0, 1'b0);
      run_directed("x_9p996", 14'h09FF, 32'hFFFF_FFFF, 1'b1, 1'b0);
`else
      run_directed("x_0p5", 14'h0080, 32'd393216, 1'b0, 1'b0);
      run_directed("x_1p5", 14'h0180, 32'd1068872, 1'b0, 1'b0);
      run_directed("x_9p996", 14'h09FF, 32'd4240052108, 1'b0, 1'b0);
`endif
      run_directed("x_10", 14'h0A00, 32'hFFFF_FFFF, 1'b1, 1'b0);
      run_directed("x_m6", 14'h3A00, 32'd0, 1'b0, 1'b1);
      run_directed("x_m5", 14'h3B00, 32'd1766, 1'b0, 1'b0);

      stall_test();
      random_test(400);
      reset_flush_test();

      check("final_queue_empty", 64'(exp_q.size()), 64'(0));
      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
